// File: rtl/alu_ctrl_pipe.sv
// Registered, handshaked ALU control decoder with a one-deep output bundle.
// Define ALU_CTRL_MUL_EN to build the iterative shift-add multiplier for opcode 00010.
module alu_ctrl_pipe #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       opcode,
  input  logic [1:0]       func,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             cin,
  output logic             inv_a,
  output logic             inv_b,
  output logic             sign,
  output logic [4:0]       op,
  output logic [WIDTH-1:0] a_q,
  output logic [WIDTH-1:0] b_q,
  output logic [WIDTH-1:0] mul_p,
  output logic             err
);

  logic [4:0]       dec_op;
  logic             dec_cin, dec_inv_a, dec_inv_b, dec_sign, dec_err, dec_mul;

  logic             ov_q, ov_d;
  logic             cin_q, cin_d, inva_q, inva_d, invb_q, invb_d, sign_q, sign_d;
  logic             err_q, err_d;
  logic [4:0]       op_q, op_d;
  logic [WIDTH-1:0] aq_q, aq_d, bq_q, bq_d, mulp_q, mulp_d;
  logic             accept;

  // Combinational decode of the incoming instruction
  always_comb begin
    dec_op    = '0;
    dec_cin   = 1'b0;
    dec_inv_a = 1'b0;
    dec_inv_b = 1'b0;
    dec_sign  = 1'b0;
    dec_err   = 1'b0;
    dec_mul   = 1'b0;
    casez (opcode)
      5'b00000, 5'b00001: ;
`ifdef ALU_CTRL_MUL_EN
      5'b00010: dec_mul = 1'b1;
`endif
      5'b01000: begin dec_op = 5'b00100; dec_sign = 1'b1; end
      5'b01001: begin dec_op = 5'b00100; dec_cin = 1'b1; dec_inv_a = 1'b1; dec_sign = 1'b1; end
      5'b01010: dec_op = 5'b00110;
      5'b01011: begin dec_op = 5'b00111; dec_inv_b = 1'b1; end
      5'b10100: dec_op = 5'b00000;
      5'b10101: dec_op = 5'b00001;
      5'b10110: begin dec_op = 5'b01000; dec_cin = 1'b1; end
      5'b10111: dec_op = 5'b00011;
      5'b1000?, 5'b10011, 5'b11000, 5'b001??: begin dec_op = 5'b00100; dec_sign = 1'b1; end
      5'b11001: begin dec_op = 5'b01001; dec_sign = 1'b1; end
      5'b10010: dec_op = 5'b10000;
      5'b11100, 5'b01100: begin dec_op = 5'b01010; dec_sign = 1'b1; end
      5'b11101, 5'b01110: begin
        dec_op = 5'b01011; dec_cin = 1'b1; dec_inv_b = 1'b1; dec_sign = 1'b1;
      end
      5'b11110: begin dec_op = 5'b01100; dec_cin = 1'b1; dec_inv_b = 1'b1; dec_sign = 1'b1; end
      5'b11111: begin dec_op = 5'b01101; dec_sign = 1'b1; end
      5'b01101: begin dec_op = 5'b01110; dec_sign = 1'b1; end
      5'b01111: begin dec_op = 5'b01111; dec_cin = 1'b1; dec_inv_b = 1'b1; dec_sign = 1'b1; end
      5'b11011: begin
        case (func)
          2'b00: begin dec_op = 5'b00100; dec_sign = 1'b1; end
          2'b01: begin dec_op = 5'b00100; dec_cin = 1'b1; dec_inv_a = 1'b1; dec_sign = 1'b1; end
          2'b10: dec_op = 5'b00110;
          default: begin dec_op = 5'b00111; dec_inv_b = 1'b1; end
        endcase
      end
      5'b11010: begin
        dec_cin = 1'b1;
        case (func)
          2'b00: dec_op = 5'b00000;
          2'b01: dec_op = 5'b00001;
          2'b10: dec_op = 5'b01000;
          default: dec_op = 5'b00011;
        endcase
      end
      default: dec_err = 1'b1;
    endcase
  end

`ifdef ALU_CTRL_MUL_EN
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MUL  = 1'b1;
  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [0:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d, acc_next;

  assign in_ready = (state_q == S_IDLE) && (!ov_q || out_ready);
`else
  assign in_ready = !ov_q || out_ready;
`endif

  assign accept = in_valid && in_ready;

  always_comb begin
    ov_d   = ov_q;
    cin_d  = cin_q;
    inva_d = inva_q;
    invb_d = invb_q;
    sign_d = sign_q;
    err_d  = err_q;
    op_d   = op_q;
    aq_d   = aq_q;
    bq_d   = bq_q;
    mulp_d = mulp_q;
    if (accept && !dec_mul) begin
      ov_d   = 1'b1;
      cin_d  = dec_cin;
      inva_d = dec_inv_a;
      invb_d = dec_inv_b;
      sign_d = dec_sign;
      err_d  = dec_err;
      op_d   = dec_op;
      aq_d   = a;
      bq_d   = b;
      mulp_d = '0;
    end else if (out_ready) begin
      ov_d = 1'b0;
    end
`ifdef ALU_CTRL_MUL_EN
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    acc_next = acc_q + (bq_q[cnt_q] ? (aq_q << cnt_q) : '0);
    if (accept && dec_mul) begin
      // a_q/b_q double as multiplicand/multiplier; no bundle is valid meanwhile
      state_d = S_MUL;
      aq_d    = a;
      bq_d    = b;
      acc_d   = '0;
      cnt_d   = '0;
    end
    if (state_q == S_MUL) begin
      acc_d = acc_next;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_LAST) begin
        state_d = S_IDLE;
        cnt_d   = '0;
        mulp_d  = acc_next;
        op_d    = 5'b00100;
        cin_d   = 1'b0;
        inva_d  = 1'b0;
        invb_d  = 1'b0;
        sign_d  = 1'b0;
        err_d   = 1'b0;
        ov_d    = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov_q   <= 1'b0;
      cin_q  <= 1'b0;
      inva_q <= 1'b0;
      invb_q <= 1'b0;
      sign_q <= 1'b0;
      err_q  <= 1'b0;
      op_q   <= '0;
      aq_q   <= '0;
      bq_q   <= '0;
      mulp_q <= '0;
    end else begin
      ov_q   <= ov_d;
      cin_q  <= cin_d;
      inva_q <= inva_d;
      invb_q <= invb_d;
      sign_q <= sign_d;
      err_q  <= err_d;
      op_q   <= op_d;
      aq_q   <= aq_d;
      bq_q   <= bq_d;
      mulp_q <= mulp_d;
    end
  end

`ifdef ALU_CTRL_MUL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  end
`endif

  assign out_valid = ov_q;
  assign cin       = cin_q;
  assign inv_a     = inva_q;
  assign inv_b     = invb_q;
  assign sign      = sign_q;
  assign err       = err_q;
  assign op        = op_q;
  assign a_q       = aq_q;
  assign b_q       = bq_q;
  assign mul_p     = mulp_q;

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// Randomized + directed bench for alu_ctrl_pipe against a transaction-level reference.
// MUL scenarios are included when ALU_CTRL_MUL_EN is defined.
module tb_alu_ctrl_pipe;
  localparam int unsigned W = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_ready, out_valid, out_ready;
  logic [4:0] opcode, op;
  logic [1:0] func;
  logic [W-1:0] a, b, a_q, b_q, mul_p;
  logic cin, inv_a, inv_b, sign, err;

  int total = 0;
  int bad = 0;

`ifdef ALU_CTRL_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  alu_ctrl_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .func(func), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .cin(cin), .inv_a(inv_a), .inv_b(inv_b), .sign(sign), .op(op),
    .a_q(a_q), .b_q(b_q), .mul_p(mul_p), .err(err)
  );

  always #5 clk = ~clk;

  // Reference table entry: {op[4:0], cin, inv_a, inv_b, sign, err}
  logic [9:0] tbl [32];

  bit           m_ov, m_busy;
  int           m_cnt;
  logic [9:0]   m_ctl, p_ctl;
  logic [W-1:0] m_a, m_b, m_p, p_a, p_b, p_p;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [9:0] row(input logic [4:0] o, input bit c, input bit ia,
                                     input bit ib, input bit s);
    return {o, c, ia, ib, s, 1'b0};
  endfunction

  task automatic build_table();
    for (int i = 0; i < 32; i++) tbl[i] = 10'b00000_0000_1;
    tbl[5'b00000] = '0;
    tbl[5'b00001] = '0;
    tbl[5'b01000] = row(5'b00100, 0, 0, 0, 1);
    tbl[5'b01001] = row(5'b00100, 1, 1, 0, 1);
    tbl[5'b01010] = row(5'b00110, 0, 0, 0, 0);
    tbl[5'b01011] = row(5'b00111, 0, 0, 1, 0);
    tbl[5'b10100] = row(5'b00000, 0, 0, 0, 0);
    tbl[5'b10101] = row(5'b00001, 0, 0, 0, 0);
    tbl[5'b10110] = row(5'b01000, 1, 0, 0, 0);
    tbl[5'b10111] = row(5'b00011, 0, 0, 0, 0);
    foreach (tbl[i]) begin
      if (i == 16 || i == 17 || i == 19 || i == 24 || (i >= 4 && i <= 7))
        tbl[i] = row(5'b00100, 0, 0, 0, 1);
    end
    tbl[5'b11001] = row(5'b01001, 0, 0, 0, 1);
    tbl[5'b10010] = row(5'b10000, 0, 0, 0, 0);
    tbl[5'b11100] = row(5'b01010, 0, 0, 0, 1);
    tbl[5'b01100] = row(5'b01010, 0, 0, 0, 1);
    tbl[5'b11101] = row(5'b01011, 1, 0, 1, 1);
    tbl[5'b01110] = row(5'b01011, 1, 0, 1, 1);
    tbl[5'b11110] = row(5'b01100, 1, 0, 1, 1);
    tbl[5'b11111] = row(5'b01101, 0, 0, 0, 1);
    tbl[5'b01101] = row(5'b01110, 0, 0, 0, 1);
    tbl[5'b01111] = row(5'b01111, 1, 0, 1, 1);
  endtask

  function automatic logic [9:0] ref_ctl(input logic [4:0] opc, input logic [1:0] fn);
    logic [9:0] r;
    r = tbl[opc];
    if (opc == 5'b11011) r = tbl[{3'b010, fn}];
    if (opc == 5'b11010) begin
      case (fn)
        2'b00: r = row(5'b00000, 1, 0, 0, 0);
        2'b01: r = row(5'b00001, 1, 0, 0, 0);
        2'b10: r = row(5'b01000, 1, 0, 0, 0);
        default: r = row(5'b00011, 1, 0, 0, 0);
      endcase
    end
    return r;
  endfunction

  task automatic model_reset();
    m_ov = 0; m_busy = 0; m_cnt = 0;
    m_ctl = '0; m_a = '0; m_b = '0; m_p = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ov"}, 64'(out_valid), 64'd0);
    check({tag, "_ctl"}, 64'({op, cin, inv_a, inv_b, sign, err}), 64'd0);
    check({tag, "_ops"}, 64'({a_q, b_q, mul_p}), 64'd0);
  endtask

  // One clock: drive at negedge, check in_ready, advance model at posedge, check outputs.
  task automatic cycle(input bit v, input logic [4:0] opc, input logic [1:0] fn,
                       input logic [W-1:0] aa, input logic [W-1:0] bb, input bit ordy);
    bit rdy, acc;
    logic [2*W-1:0] prod;
    @(negedge clk);
    in_valid = v; opcode = opc; func = fn; a = aa; b = bb; out_ready = ordy;
    #1;
    rdy = !m_busy && (!m_ov || ordy);
    check("in_ready", 64'(in_ready), 64'(rdy));
    acc = v && rdy;
    @(posedge clk);
    if (m_busy) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_busy = 0; m_ov = 1;
        m_ctl = p_ctl; m_a = p_a; m_b = p_b; m_p = p_p;
      end
    end else if (acc && MUL_EN && opc == 5'b00010) begin
      prod = aa * bb;
      m_busy = 1; m_cnt = W; m_ov = 0;
      p_ctl = row(5'b00100, 0, 0, 0, 0);
      p_a = aa; p_b = bb; p_p = prod[W-1:0];
    end else if (acc) begin
      m_ov = 1; m_ctl = ref_ctl(opc, fn); m_a = aa; m_b = bb; m_p = '0;
    end else if (ordy) begin
      m_ov = 0;
    end
    #1;
    check("out_valid", 64'(out_valid), 64'(m_ov));
    if (m_ov) begin
      check("ctrl", 64'({op, cin, inv_a, inv_b, sign, err}), 64'(m_ctl));
      check("operands", 64'({a_q, b_q}), 64'({m_a, m_b}));
      check("mul_p", 64'(mul_p), 64'(m_p));
    end
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) cycle(0, 5'd0, 2'd0, '0, '0, ordy);
  endtask

  initial begin
    build_table();
    model_reset();
    rst_n = 0;
    in_valid = 1; opcode = 5'b01001; func = 2'b01; a = 16'h1234; b = 16'h5678; out_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1;
    in_valid = 0; out_ready = 0;
    #1;
    check("ready_after_reset", 64'(in_ready), 64'd1);

    // func-selected decode, back to back
    for (int f = 0; f < 4; f++)
      cycle(1, 5'b11011, 2'(f), 16'(f + 1), 16'(f + 100), 1);
    for (int f = 0; f < 4; f++)
      cycle(1, 5'b11010, 2'(f), 16'hAAAA, 16'h5555, 1);

    // illegal then nop
    cycle(1, 5'b00011, 2'b00, 16'h0F0F, 16'hF0F0, 1);
    cycle(1, 5'b00001, 2'b00, 16'h0001, 16'h0002, 1);
    idle(1, 1);

    // backpressure: bundle must hold while out_ready is low
    cycle(1, 5'b01001, 2'b00, 16'hBEEF, 16'hCAFE, 1);
    for (int i = 0; i < 5; i++) cycle(1, 5'b01010, 2'b00, 16'h1111, 16'h2222, 0);
    cycle(1, 5'b01010, 2'b00, 16'h1111, 16'h2222, 1);
    idle(1, 1);

    // 00010: multiplier or illegal depending on build
    cycle(1, 5'b00010, 2'b00, 16'd7, 16'd9, 1);
    idle(W + 1, 1);
    cycle(1, 5'b00010, 2'b00, 16'hFFFF, 16'd2, 1);
    idle(W + 1, 1);
    if (MUL_EN) begin
      // product held under backpressure, then reset mid-multiply
      cycle(1, 5'b00010, 2'b00, 16'h0123, 16'h0456, 1);
      idle(W + 3, 0);
      idle(1, 1);
      cycle(1, 5'b00010, 2'b00, 16'd300, 16'd500, 1);
      idle(4, 1);
      @(negedge clk);
      rst_n = 0;
      #1;
      check_all_zero("mid_mul_reset");
      @(negedge clk);
      rst_n = 1;
      model_reset();
      idle(W + 4, 1);
    end

    // random traffic
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
            16'($urandom), 16'($urandom), ($urandom_range(0, 3) != 0));
    end
    idle(W + 2, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
